// File: rtl/fibonacci_sequencer.sv
// Iterative Fibonacci term generator: a = F(n), b = F(n+1) with one carry bit of headroom.
// Define FIB_BACKSTEP_EN to honour 'back' and build the b - a retreat path.
module fibonacci_sequencer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 6,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic             back,
  output logic [WIDTH-1:0] term,
  output logic [IDX_W-1:0] index,
  output logic             at_max,
  output logic             wrap_pulse,
  output logic             sat_pulse
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_d, sat_d;
  logic             do_step;

`ifdef FIB_BACKSTEP_EN
  logic do_back;
  // step and back together cancel out and hold the current term
  assign do_step = step & ~back;
  assign do_back = back & ~step;
`else
  logic unused_back;
  assign do_step     = step;
  assign unused_back = back;
`endif

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (clr) begin
      a_d   = '0;
      b_d   = (WIDTH+1)'(1);
      idx_d = '0;
    end else if (do_step) begin
      if (b_q[WIDTH]) begin
        if (MODE == 0) begin
          a_d    = '0;
          b_d    = (WIDTH+1)'(1);
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end else begin
        a_d   = b_q[WIDTH-1:0];
        b_d   = {1'b0, a_q} + b_q;
        idx_d = idx_q + IDX_W'(1);
      end
    end
`ifdef FIB_BACKSTEP_EN
    else if (do_back && (idx_q != '0)) begin
      // F(n-1) = F(n+1) - F(n) always fits in WIDTH bits
      a_d   = WIDTH'(b_q - {1'b0, a_q});
      b_d   = {1'b0, a_q};
      idx_d = idx_q - IDX_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= (WIDTH+1)'(1);
      idx_q      <= '0;
      wrap_pulse <= 1'b0;
      sat_pulse  <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      wrap_pulse <= wrap_d;
      sat_pulse  <= sat_d;
    end
  end

  assign term   = a_q;
  assign index  = idx_q;
  assign at_max = b_q[WIDTH];

endmodule
